byte_packer: RTL and testbench

Upstream feeder for the encrypter stage. Accepts an 8-bit byte stream on a valid/ready interface and packs byte pairs into 16-bit words. Each word is stored with a 4-bit key-rotation offset in a small word FIFO. The block serves the encrypter's four-phase reqIn/rdyIn request handshake, driving the encrypter's dataIn and rot_offset inputs.

---
 rtl/byte_packer_pkg.sv | 24 ++
 rtl/byte_packer_sync_fifo.sv | 55 +++++
 rtl/byte_packer.sv | 136 +++++++++++++
 tb/tb_byte_packer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/byte_packer_pkg.sv
// byte_packer_pkg: constants and types shared by byte_packer and its word FIFO.
//   ENCRYPTER_WIDTH    - width of the encrypter dataIn word
//   KEY_ROTATION_WIDTH - width of the key-rotation offset
//   BYTE_WIDTH         - width of the incoming byte stream
//   hs_state_t         - encrypter request/ready handshake states
//   fifo_entry_t       - buffered {offset, word} entry
package byte_packer_pkg;

  localparam int ENCRYPTER_WIDTH    = 16;
  localparam int KEY_ROTATION_WIDTH = 4;
  localparam int BYTE_WIDTH         = 8;

  typedef enum logic [1:0] {
    HS_IDLE  = 2'd0,
    HS_SETUP = 2'd1,
    HS_HOLD  = 2'd2
  } hs_state_t;

  typedef struct packed {
    logic [KEY_ROTATION_WIDTH-1:0] offset;
    logic [ENCRYPTER_WIDTH-1:0]    word;
  } fifo_entry_t;

endpackage

// File: rtl/byte_packer_sync_fifo.sv
// sync_fifo: single-clock FIFO, synchronous active-low reset.
//   clk, reset          - clock, sync active-low reset (discards contents)
//   push, push_data     - write request (ignored when full)
//   pop, pop_data       - read request (ignored when empty); pop_data shows the head
//   full, empty, count  - occupancy status
module sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = push && !full;
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: pointers/count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth: pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/byte_packer.sv
// byte_packer: packs a valid/ready byte stream into 16-bit words, buffers
// {offset, word} entries, and serves the encrypter's four-phase req/rdy
// handshake.
//   clk, reset                 - clock, sync active-low reset
//   byte_in/valid/ready        - byte stream input
//   flush                      - pad (PAD_BYTE) and push a pending half-word
//   cfg_offset                 - fixed rotation offset (non-auto build)
//   enc_req, enc_rdy           - encrypter reqIn / rdyIn
//   enc_data, enc_rot_offset   - encrypter dataIn / rot_offset
//   fifo_count, half_pending   - status
// Build option: ROT_OFFSET_AUTO_EN selects a per-push incrementing offset
// counter instead of cfg_offset.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [BYTE_WIDTH-1:0] PAD_BYTE   = 8'h00
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [BYTE_WIDTH-1:0]           byte_in,
  input  logic                            byte_valid,
  output logic                            byte_ready,
  input  logic                            flush,
  input  logic [KEY_ROTATION_WIDTH-1:0]   cfg_offset,
  input  logic                            enc_req,
  output logic                            enc_rdy,
  output logic [ENCRYPTER_WIDTH-1:0]      enc_data,
  output logic [KEY_ROTATION_WIDTH-1:0]   enc_rot_offset,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            half_pending
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                          take, push, push_pair, push_flush, pop;
  logic                          fifo_full, fifo_empty;
  logic [BYTE_WIDTH-1:0]         held_byte;
  logic [KEY_ROTATION_WIDTH-1:0] push_offset;
  fifo_entry_t                   push_entry, head_entry;
  hs_state_t                     state, state_nxt;

  // Registered count only: no path from enc_req.
  assign byte_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign take       = byte_valid && byte_ready;

  // Second byte completes a word. Flush acts on the post-byte state: with a
  // byte held and none arriving it pads the held byte (needs space), with no
  // byte held but one arriving it pads the new one (space already implied by
  // byte_ready). A byte completing a pair leaves nothing for flush to do.
  assign push_pair  = take && half_pending;
  assign push_flush = flush && (half_pending ? (!take && !fifo_full) : take);
  assign push       = push_pair || push_flush;

  always_comb begin
    push_entry             = '0;
    push_entry.offset      = push_offset;
    push_entry.word[15:8]  = half_pending ? held_byte : byte_in;
    push_entry.word[7:0]   = push_pair ? byte_in : PAD_BYTE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      held_byte    <= '0;
      half_pending <= 1'b0;
    end else begin
      if (take && !half_pending) held_byte <= byte_in;
      if (push)      half_pending <= 1'b0;
      else if (take) half_pending <= 1'b1;
    end
  end

`ifdef ROT_OFFSET_AUTO_EN
  logic [KEY_ROTATION_WIDTH-1:0] rot_cnt;
  logic                          unused_cfg_offset;

  assign unused_cfg_offset = ^cfg_offset;
  assign push_offset       = rot_cnt;   // pre-increment value goes with the word

  always_ff @(posedge clk) begin
    if (!reset)    rot_cnt <= '0;
    else if (push) rot_cnt <= rot_cnt + 1'b1;
  end
`else
  assign push_offset = cfg_offset;
`endif

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Handshake FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state <= HS_IDLE;
    else        state <= state_nxt;
  end

  // Handshake FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      HS_IDLE:  if (enc_req && !fifo_empty) state_nxt = HS_SETUP;
      HS_SETUP: state_nxt = HS_HOLD;
      HS_HOLD:  if (!enc_req) state_nxt = HS_IDLE;
      default:  state_nxt = HS_IDLE;
    endcase
  end

  // Handshake FSM: outputs. SETUP gives the data one cycle ahead of rdy.
  always_comb begin
    pop     = (state == HS_IDLE) && enc_req && !fifo_empty;
    enc_rdy = (state == HS_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enc_data       <= '0;
      enc_rot_offset <= '0;
    end else if (pop) begin
      enc_data       <= head_entry.word;
      enc_rot_offset <= head_entry.offset;
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
module tb_byte_packer;
  import byte_packer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush;
  logic [3:0]  cfg_offset;
  logic        enc_req;
  logic        enc_rdy;
  logic [15:0] enc_data;
  logic [3:0]  enc_rot_offset;
  logic [2:0]  fifo_count;
  logic        half_pending;

  int errors = 0;
  int checks = 0;

  byte_packer #(.FIFO_DEPTH(4), .PAD_BYTE(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .flush          (flush),
    .cfg_offset     (cfg_offset),
    .enc_req        (enc_req),
    .enc_rdy        (enc_rdy),
    .enc_data       (enc_data),
    .enc_rot_offset (enc_rot_offset),
    .fifo_count     (fifo_count),
    .half_pending   (half_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  // Full request cycle: pop edge, rdy rise edge, release edge.
  task automatic drain(input string tag, input logic [15:0] ed, input logic [3:0] eo);
    enc_req = 1'b1;
    tick();
    check({tag, "_data"}, enc_data, ed);
    check({tag, "_off"}, enc_rot_offset, eo);
    check({tag, "_rdy_setup"}, enc_rdy, 1'b0);
    tick();
    check({tag, "_rdy_hold"}, enc_rdy, 1'b1);
    enc_req = 1'b0;
    tick();
    check({tag, "_rdy_low"}, enc_rdy, 1'b0);
  endtask

  logic [3:0] exp_off;

  initial begin
    reset = 1'b0; byte_in = '0; byte_valid = 1'b0; flush = 1'b0;
    cfg_offset = 4'h5; enc_req = 1'b0;
    tick(); tick();
    check("rst_rdy", enc_rdy, 1'b0);
    check("rst_data", enc_data, 16'h0000);
    check("rst_off", enc_rot_offset, 4'h0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_half", half_pending, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_bready", byte_ready, 1'b1);

`ifdef ROT_OFFSET_AUTO_EN
    exp_off = 4'h0;
`else
    exp_off = 4'h5;
`endif
    // Basic pair
    send_byte(8'hCC);
    check("first_half", half_pending, 1'b1);
    check("first_count", fifo_count, 3'd0);
    send_byte(8'hE3);
    check("pair_half", half_pending, 1'b0);
    check("pair_count", fifo_count, 3'd1);
    drain("basic", 16'hCCE3, exp_off);
    check("basic_empty", fifo_count, 3'd0);

    // Fill to full, ninth byte refused
    cfg_offset = 4'h3;
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    check("six_count", fifo_count, 3'd3);
    check("six_bready", byte_ready, 1'b1);
    send_byte(8'h07);
    send_byte(8'h08);
    check("full_count", fifo_count, 3'd4);
    check("full_bready", byte_ready, 1'b0);
    send_byte(8'h09);
    check("ninth_half", half_pending, 1'b0);
    check("ninth_count", fifo_count, 3'd4);
`ifdef ROT_OFFSET_AUTO_EN
    drain("fill0", 16'h0102, 4'h1);
    drain("fill1", 16'h0304, 4'h2);
    drain("fill2", 16'h0506, 4'h3);
    drain("fill3", 16'h0708, 4'h4);
`else
    drain("fill0", 16'h0102, 4'h3);
    drain("fill1", 16'h0304, 4'h3);
    drain("fill2", 16'h0506, 4'h3);
    drain("fill3", 16'h0708, 4'h3);
`endif
    check("fill_empty", fifo_count, 3'd0);

    // Flush of a held byte, then byte+flush in one cycle
    cfg_offset = 4'hC;
    send_byte(8'hF0);
    check("flush_pre_half", half_pending, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_half", half_pending, 1'b0);
    check("flush_count", fifo_count, 3'd1);
    flush = 1'b1;  // no pending byte: no effect
    tick();
    flush = 1'b0;
    check("flush_noop_count", fifo_count, 3'd1);
`ifdef ROT_OFFSET_AUTO_EN
    drain("flush", 16'hF000, 4'h5);
`else
    drain("flush", 16'hF000, 4'hC);
`endif
    byte_in = 8'hAB; byte_valid = 1'b1; flush = 1'b1;
    tick();
    byte_valid = 1'b0; flush = 1'b0;
    check("bflush_half", half_pending, 1'b0);
    check("bflush_count", fifo_count, 3'd1);
`ifdef ROT_OFFSET_AUTO_EN
    drain("bflush", 16'hAB00, 4'h6);
`else
    drain("bflush", 16'hAB00, 4'hC);
`endif

    // Request against empty FIFO
    enc_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("empty_req_rdy", enc_rdy, 1'b0);
    end
    send_byte(8'h12);
    send_byte(8'h34);
    check("late_count", fifo_count, 3'd1);
    check("late_rdy0", enc_rdy, 1'b0);
    tick();
    check("late_data", enc_data, 16'h1234);
    check("late_rdy1", enc_rdy, 1'b0);
    check("late_popped", fifo_count, 3'd0);
    tick();
    check("late_rdy2", enc_rdy, 1'b1);
    enc_req = 1'b0;
    tick();
    check("late_rdy_low", enc_rdy, 1'b0);

    // Offset sequence over 17 words from a fresh reset
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cfg_offset = 4'(i) ^ 4'hA;
      send_byte(8'(i));
      send_byte(~8'(i));
      cfg_offset = 4'h0;  // stored offset must not follow later changes
`ifdef ROT_OFFSET_AUTO_EN
      exp_off = 4'(i);
`else
      exp_off = 4'(i) ^ 4'hA;
`endif
      drain("seq", {8'(i), ~8'(i)}, exp_off);
    end

    // Reset while in HOLD with two words queued and a byte held
    send_byte(8'h11); send_byte(8'h22);
    send_byte(8'h33); send_byte(8'h44);
    enc_req = 1'b1;
    tick();
    check("hold_data", enc_data, 16'h1122);
    tick();
    check("hold_rdy", enc_rdy, 1'b1);
    send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h77);
    check("hold_count", fifo_count, 3'd2);
    check("hold_half", half_pending, 1'b1);
    reset = 1'b0;
    tick();
    check("hrst_rdy", enc_rdy, 1'b0);
    check("hrst_count", fifo_count, 3'd0);
    check("hrst_half", half_pending, 1'b0);
    check("hrst_data", enc_data, 16'h0000);
    enc_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_rdy", enc_rdy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
